id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the 5-stage RISC pipeline. Takes instructions from fetch, drives
//  the 32x32 register file read addresses, and captures operands plus decoded control into the
//  ID/EX pipeline register. Carries a valid/ready handshake on both sides, load-use stall, flush.
// PARAMETERS
//  XLEN      32  datapath / instruction / PC width
//  RA_W      5   register address width (32 registers, r0 hard-wired zero)
// PORTS
//  clk        in   1     single clock; all state updates on posedge
//  rst        in   1     asynchronous, active-high reset
//  if_valid   in   1     fetch presents an instruction
//  if_ready   out  1     stage accepts instruction this cycle
//  if_instr   in   XLEN  instruction word
//  if_pc      in   XLEN  PC of if_instr
//  flush      in   1     branch/jump redirect: kill ID/EX contents and current input
//  rsa, rta   out  RA_W  register file read addresses (combinational from if_instr)
//  rsd, rtd   in   XLEN  register file read data (combinational, write-bypassed by the regfile)
//  ex_valid   out  1     ID/EX register holds a live instruction
//  ex_ready   in   1     execute consumes ID/EX contents this cycle
//  ex_pc, ex_rsd, ex_rtd, ex_imm  out XLEN  latched PC, operands, sign-extended imm[15:0]
//  ex_op, ex_funct  out  6     opcode [31:26], funct [5:0]
//  ex_wta     out  RA_W  destination register; ex_wen out 1 write enable; ex_load out 1 is load
// BEHAVIOUR
//  Reset: ex_valid=0 and every ex_* output 0 immediately (async); deassertion sync to clk.
//  Fields: rs=[25:21] rt=[20:16] rd=[15:11]. rsa=rs, rta=rt, always, even when if_valid=0.
//  Dest: opcode 0x00 (R-type) -> wta=rd; 0x23 LW and other ALU-imm -> wta=rt; 0x2B SW, 0x04 BEQ,
//   0x05 BNE -> ex_wen=0, ex_wta=0. ex_wen forced 0 whenever wta==0. ex_load=1 only for 0x23.
//  uses_rt: 1 for R-type, SW, BEQ, BNE; 0 otherwise.
//  hazard = ex_valid & ex_load & ex_wen & (ex_wta==rs | (uses_rt & ex_wta==rt)) & if_valid.
//  if_ready = flush | ((~ex_valid | ex_ready) & ~hazard).
//  Posedge priority: flush -> ex_valid<=0 (input discarded though if_ready=1);
//   else if (~ex_valid|ex_ready) & hazard -> bubble: ex_valid<=0, input held upstream;
//   else if (~ex_valid|ex_ready) -> ex_valid<=if_valid, capture all ex_* from if_* and rsd/rtd;
//   else (ex_valid & ~ex_ready) -> hold all ex_* unchanged.
//  Latency 1 cycle accept->ex_valid; throughput 1/cycle without hazards; load-use costs 1 bubble.
//  When ex_valid=0 the ex_* data fields are don't-care, except ex_wen which is cleared to 0.
//  rst mid-stall or mid-hazard: all state dropped; no instruction replayed.
// CONFIGURATION
//  ID_HAZARD_EN defined: load-use interlock as above; stall_cnt out 16: saturating count of bubble
//   cycles, cleared by rst.
//  ID_HAZARD_EN undefined: hazard tied 0, stall_cnt port absent; software schedules load delay slots.
// STRUCTURE
//  risc_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE), field bit positions,
//   XLEN/RA_W defaults.
//  Sub-module id_decoder (combinational): if_instr -> wta, wen, load, uses_rt, imm.
//  id_stage holds handshake, hazard logic and ID/EX register.
// TESTING
//  1 Reset: rst=1 mid-stream -> ex_valid=0, ex_wen=0, ex_rsd=0 same cycle, before any clk edge.
//  2 ADD r3,r1,r2 (0x00221820), rsd=5 rtd=7, ex_ready=1 -> next cycle ex_valid=1, ex_wta=3,
//    ex_wen=1, ex_rsd=5, ex_rtd=7.
//  3 LW r4,8(r1) then ADD r5,r4,r2 -> if_ready=0 one cycle, one ex_valid=0 bubble, ADD issues next;
//    stall_cnt=1 (ID_HAZARD_EN).
//  4 ex_ready=0 for 3 cycles with ADDI pending -> ex_* stable, if_ready=0; release -> next accepted.
//  5 flush with valid input and ex_valid=1 -> next cycle ex_valid=0, input not seen at execute.
//  6 ADDI r0,r1,-1 (0x2020FFFF) -> ex_wen=0, ex_imm=0xFFFFFFFF; SW -> ex_wen=0, no hazard on rt=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC pipeline: widths, opcode constants,
// instruction field positions and the decode class used by the ID stage.
package risc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned IMM_W  = 16;

  // Destination-register class of an instruction
  typedef enum logic [1:0] {
    CLS_RTYPE,  // writes rd, reads rt
    CLS_IMM,    // writes rt (loads and ALU-immediate)
    CLS_NOWB    // stores and branches: no write-back, reads rt
  } icls_e;

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side, register-file and execute-side signals of the decode stage.
// master: the decode stage itself; slave: its surroundings (fetch/regfile/EX).
interface id_stage_if #(
  parameter int unsigned XLEN = risc_pkg::XLEN,
  parameter int unsigned RA_W = risc_pkg::RA_W
);
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            flush;
  logic [RA_W-1:0] rsa;
  logic [RA_W-1:0] rta;
  logic [XLEN-1:0] rsd;
  logic [XLEN-1:0] rtd;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rsd;
  logic [XLEN-1:0] ex_rtd;
  logic [XLEN-1:0] ex_imm;
  logic [5:0]      ex_op;
  logic [5:0]      ex_funct;
  logic [RA_W-1:0] ex_wta;
  logic            ex_wen;
  logic            ex_load;

  modport master (
    input  if_valid, if_instr, if_pc, flush, rsd, rtd, ex_ready,
    output if_ready, rsa, rta, ex_valid, ex_pc, ex_rsd, ex_rtd, ex_imm,
           ex_op, ex_funct, ex_wta, ex_wen, ex_load
  );

  modport slave (
    output if_valid, if_instr, if_pc, flush, rsd, rtd, ex_ready,
    input  if_ready, rsa, rta, ex_valid, ex_pc, ex_rsd, ex_rtd, ex_imm,
           ex_op, ex_funct, ex_wta, ex_wen, ex_load
  );
endinterface

// File: rtl/id_decoder.sv
// Combinational instruction decoder: destination register, write enable,
// load flag, whether rt is a source operand, and sign-extended immediate.
module id_decoder
  import risc_pkg::*;
#(
  parameter int unsigned XLEN = risc_pkg::XLEN,
  parameter int unsigned RA_W = risc_pkg::RA_W
) (
  input  logic [XLEN-1:0] instr_i,
  output logic [RA_W-1:0] wta_o,
  output logic            wen_o,
  output logic            load_o,
  output logic            uses_rt_o,
  output logic [XLEN-1:0] imm_o
);

  logic [5:0] op;
  icls_e      cls;
  logic       unused_rs;

  assign op        = instr_i[OP_LSB +: 6];
  assign unused_rs = ^instr_i[RS_LSB +: RA_W];
  assign imm_o     = {{(XLEN-IMM_W){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0]};
  assign load_o    = (op == OP_LW);

  // Classify opcode, then derive destination and rt usage from the class
  always_comb begin
    cls       = CLS_IMM;
    wta_o     = '0;
    wen_o     = 1'b0;
    uses_rt_o = 1'b0;
    case (op)
      OP_RTYPE:              cls = CLS_RTYPE;
      OP_SW, OP_BEQ, OP_BNE: cls = CLS_NOWB;
      default:               cls = CLS_IMM;
    endcase
    unique case (cls)
      CLS_RTYPE: begin
        wta_o     = instr_i[RD_LSB +: RA_W];
        wen_o     = 1'b1;
        uses_rt_o = 1'b1;
      end
      CLS_IMM: begin
        wta_o     = instr_i[RT_LSB +: RA_W];
        wen_o     = 1'b1;
      end
      default: begin
        wta_o     = '0;
        wen_o     = 1'b0;
        uses_rt_o = 1'b1;
      end
    endcase
    // r0 is hard-wired zero, so a write to it is no write at all
    if (wta_o == '0) wen_o = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: drives regfile read addresses, decodes the
// instruction and captures operands/control into the ID/EX register with a
// valid/ready handshake on both sides, flush, and optional load-use interlock.
// Build option: define ID_HAZARD_EN to enable the load-use interlock and the
// stall_cnt bubble counter output.
module id_stage
  import risc_pkg::*;
#(
  parameter int unsigned XLEN = risc_pkg::XLEN,
  parameter int unsigned RA_W = risc_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst,
  id_stage_if.master        bus
`ifdef ID_HAZARD_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [RA_W-1:0] rs, rt;
  logic [RA_W-1:0] dec_wta;
  logic            dec_wen, dec_load, dec_uses_rt;
  logic [XLEN-1:0] dec_imm;
  logic            slot_free, hazard;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q,    ex_pc_d;
  logic [XLEN-1:0] ex_rsd_q,   ex_rsd_d;
  logic [XLEN-1:0] ex_rtd_q,   ex_rtd_d;
  logic [XLEN-1:0] ex_imm_q,   ex_imm_d;
  logic [5:0]      ex_op_q,    ex_op_d;
  logic [5:0]      ex_funct_q, ex_funct_d;
  logic [RA_W-1:0] ex_wta_q,   ex_wta_d;
  logic            ex_wen_q,   ex_wen_d;
  logic            ex_load_q,  ex_load_d;

  assign rs      = bus.if_instr[RS_LSB +: RA_W];
  assign rt      = bus.if_instr[RT_LSB +: RA_W];
  assign bus.rsa = rs;
  assign bus.rta = rt;

  id_decoder #(.XLEN(XLEN), .RA_W(RA_W)) u_dec (
    .instr_i   (bus.if_instr),
    .wta_o     (dec_wta),
    .wen_o     (dec_wen),
    .load_o    (dec_load),
    .uses_rt_o (dec_uses_rt),
    .imm_o     (dec_imm)
  );

  assign slot_free = ~ex_valid_q | bus.ex_ready;

`ifdef ID_HAZARD_EN
  logic [15:0] stall_q, stall_d;

  assign hazard = ex_valid_q & ex_load_q & ex_wen_q & bus.if_valid &
                  ((ex_wta_q == rs) | (dec_uses_rt & (ex_wta_q == rt)));

  // Saturating count of bubble cycles inserted by the interlock
  always_comb begin
    stall_d = stall_q;
    if (~bus.flush & slot_free & hazard & (stall_q != '1))
      stall_d = stall_q + 16'd1;
  end

  // Bubble counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  logic unused_uses_rt;
  assign unused_uses_rt = dec_uses_rt;
  assign hazard         = 1'b0;
`endif

  assign bus.if_ready = bus.flush | (slot_free & ~hazard);

  // ID/EX next state: flush, then bubble, then capture, else hold
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_rsd_d   = ex_rsd_q;
    ex_rtd_d   = ex_rtd_q;
    ex_imm_d   = ex_imm_q;
    ex_op_d    = ex_op_q;
    ex_funct_d = ex_funct_q;
    ex_wta_d   = ex_wta_q;
    ex_wen_d   = ex_wen_q;
    ex_load_d  = ex_load_q;
    if (bus.flush || (slot_free && hazard)) begin
      ex_valid_d = 1'b0;
      ex_wen_d   = 1'b0;
    end else if (slot_free) begin
      ex_valid_d = bus.if_valid;
      ex_pc_d    = bus.if_pc;
      ex_rsd_d   = bus.rsd;
      ex_rtd_d   = bus.rtd;
      ex_imm_d   = dec_imm;
      ex_op_d    = bus.if_instr[OP_LSB +: 6];
      ex_funct_d = bus.if_instr[5:0];
      ex_wta_d   = dec_wta;
      ex_wen_d   = bus.if_valid & dec_wen;
      ex_load_d  = dec_load;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_rsd_q   <= '0;
      ex_rtd_q   <= '0;
      ex_imm_q   <= '0;
      ex_op_q    <= '0;
      ex_funct_q <= '0;
      ex_wta_q   <= '0;
      ex_wen_q   <= 1'b0;
      ex_load_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_rsd_q   <= ex_rsd_d;
      ex_rtd_q   <= ex_rtd_d;
      ex_imm_q   <= ex_imm_d;
      ex_op_q    <= ex_op_d;
      ex_funct_q <= ex_funct_d;
      ex_wta_q   <= ex_wta_d;
      ex_wen_q   <= ex_wen_d;
      ex_load_q  <= ex_load_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_pc    = ex_pc_q;
  assign bus.ex_rsd   = ex_rsd_q;
  assign bus.ex_rtd   = ex_rtd_q;
  assign bus.ex_imm   = ex_imm_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_funct = ex_funct_q;
  assign bus.ex_wta   = ex_wta_q;
  assign bus.ex_wen   = ex_wen_q;
  assign bus.ex_load  = ex_load_q;

endmodule
